// File: rtl/test_pattern_gen.sv
// Test pattern generator: raster timing counters plus four selectable
// palette-index patterns (quadrants, bars, checkerboard, markers). Every
// output is registered one clock after the counters so they stay aligned.
module test_pattern_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CHK_LOG2 = 5,
   parameter int   MARK     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic [3:0] luma_in,
   input  logic [3:0] hue_base,
   input  logic       scroll,
   output logic [7:0] uv,
   output logic [9:0] row,
   output logic [9:0] col,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic [3:0] region
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 16;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] H_HALF   = 12'(H_ACTIVE / 2);
   localparam logic [11:0] V_HALF   = 12'(V_ACTIVE / 2);
   localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      MODE_QUAD    = 2'd0,
      MODE_BARS    = 2'd1,
      MODE_CHECK   = 2'd2,
      MODE_MARKERS = 2'd3
   } mode_e;

   logic [11:0] hCnt_q, hCnt_d, vCnt_q, vCnt_d;
   logic [11:0] barPix_q, barPix_d;
   logic [3:0]  barIdx_q, barIdx_d;
   logic [7:0]  frameCnt_q, frameCnt_d;
   mode_e       modeLat_q, modeLat_d;
   logic [3:0]  hueLat_q, hueLat_d;
   logic        scrollLat_q, scrollLat_d;

   logic [7:0]  uv_q, uv_d;
   logic [9:0]  row_q, row_d, col_q, col_d;
   logic        active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic        frameStart_q, frameStart_d;
   logic [3:0]  region_q, region_d;

   logic        atOrigin;
   mode_e       modeEff;
   logic [3:0]  hueEff;
   logic        scrollEff;
   logic        pixActive;
   logic [1:0]  rowReg, colReg;
   logic [3:0]  quadHue, barHue, markHue;

   // Marker band decode for one axis: 1 near the start, 2 centred, 3 near the end.
   function automatic logic [1:0] regionOf(input logic [11:0] x, input int ext);
      logic [1:0] r;
      r = 2'd0;
      if (x >= 12'(MARK) && x <= 12'(2 * MARK - 1)) r = 2'd1;
      else if (x >= 12'(ext / 2 - MARK / 2) && x <= 12'(ext / 2 + MARK / 2 - 1)) r = 2'd2;
      else if (x >= 12'(ext - 2 * MARK) && x <= 12'(ext - MARK - 1)) r = 2'd3;
      return r;
   endfunction

   // The pixel at the origin already uses the live controls, so mid-frame
   // changes only ever land on a frame boundary.
   assign atOrigin  = (hCnt_q == 12'd0) && (vCnt_q == 12'd0);
   assign modeEff   = atOrigin ? mode_e'(mode) : modeLat_q;
   assign hueEff    = atOrigin ? hue_base : hueLat_q;
   assign scrollEff = atOrigin ? scroll : scrollLat_q;

   // Raster counters, the bar sub-counter that replaces a divider, the frame
   // counter and the per-frame control latches.
   always_comb begin
      hCnt_d      = hCnt_q + 12'd1;
      vCnt_d      = vCnt_q;
      frameCnt_d  = frameCnt_q;
      barPix_d    = barPix_q + 12'd1;
      barIdx_d    = barIdx_q;
      modeLat_d   = modeEff;
      hueLat_d    = hueEff;
      scrollLat_d = scrollEff;
      if (hCnt_q == H_LAST) begin
         hCnt_d   = 12'd0;
         barPix_d = 12'd0;
         barIdx_d = 4'd0;
         if (vCnt_q == V_LAST) begin
            vCnt_d     = 12'd0;
            frameCnt_d = frameCnt_q + 8'd1;
         end else begin
            vCnt_d = vCnt_q + 12'd1;
         end
      end else if (barPix_q == BAR_LAST) begin
         barPix_d = 12'd0;
         barIdx_d = barIdx_q + 4'd1;
      end
   end

   // Pattern and sync decode for the pixel the counters point at.
   always_comb begin
      pixActive = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
      rowReg    = regionOf(vCnt_q, V_ACTIVE);
      colReg    = regionOf(hCnt_q, H_ACTIVE);
      quadHue   = hueEff + {vCnt_q >= V_HALF, hCnt_q >= H_HALF, 2'b00};
      barHue    = barIdx_q + (scrollEff ? frameCnt_q[5:2] : 4'd0);
      markHue   = ((({2'b00, rowReg} - 4'd1) * 4'd3) + ({2'b00, colReg} - 4'd1)) * 4'd2;
      uv_d      = 8'h00;
      region_d  = 4'h0;
      if (pixActive) begin
         case (modeEff)
            MODE_QUAD:  uv_d = {quadHue, luma_in};
            MODE_BARS:  uv_d = {barHue, luma_in};
            MODE_CHECK: uv_d = (hCnt_q[CHK_LOG2] ^ vCnt_q[CHK_LOG2]) ? 8'h0F : 8'h00;
            default: begin
               region_d = {rowReg, colReg};
               if (rowReg != 2'd0 && colReg != 2'd0) uv_d = {markHue, 4'hF};
            end
         endcase
      end
      row_d        = vCnt_q[9:0];
      col_d        = hCnt_q[9:0];
      active_d     = pixActive;
      hsync_d      = (hCnt_q >= HS_FIRST && hCnt_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
      vsync_d      = (vCnt_q >= VS_FIRST && vCnt_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
      frameStart_d = atOrigin;
   end

   // State and output registers; reset parks everything at the origin idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hCnt_q       <= 12'd0;
         vCnt_q       <= 12'd0;
         barPix_q     <= 12'd0;
         barIdx_q     <= 4'd0;
         frameCnt_q   <= 8'd0;
         modeLat_q    <= MODE_QUAD;
         hueLat_q     <= 4'd0;
         scrollLat_q  <= 1'b0;
         uv_q         <= 8'h00;
         row_q        <= 10'd0;
         col_q        <= 10'd0;
         active_q     <= 1'b0;
         hsync_q      <= ~SYNC_POL;
         vsync_q      <= ~SYNC_POL;
         frameStart_q <= 1'b0;
         region_q     <= 4'h0;
      end else begin
         hCnt_q       <= hCnt_d;
         vCnt_q       <= vCnt_d;
         barPix_q     <= barPix_d;
         barIdx_q     <= barIdx_d;
         frameCnt_q   <= frameCnt_d;
         modeLat_q    <= modeLat_d;
         hueLat_q     <= hueLat_d;
         scrollLat_q  <= scrollLat_d;
         uv_q         <= uv_d;
         row_q        <= row_d;
         col_q        <= col_d;
         active_q     <= active_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         frameStart_q <= frameStart_d;
         region_q     <= region_d;
      end
   end

   assign uv          = uv_q;
   assign row         = row_q;
   assign col         = col_q;
   assign active      = active_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frameStart_q;
   assign region      = region_q;

endmodule
